// File: rtl/dma_mem_to_bus.sv
// dma_mem_to_bus: reads words from port B of the CI scratch-pad RAM and
// burst-writes them onto the system bus, one arbitration per burst.
module dma_mem_to_bus #(
    parameter int maxBurst = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] busStartAddress,
    input  logic [8:0]  memStartAddress,
    input  logic [9:0]  blockSize,
    input  logic [7:0]  burstSize,
    output logic        busy,
    output logic        done,
    output logic        errorFlag,
    output logic [8:0]  memAddress,
    input  logic [31:0] memData,
    output logic        busRequest,
    input  logic        busGrant,
    output logic        beginTransaction,
    output logic [31:0] addressData,
    output logic [7:0]  burstCount,
    output logic [31:0] writeData,
    output logic        dataValid,
    input  logic        busBusy,
    output logic        endTransaction,
    input  logic        busError
);
    typedef enum logic [2:0] {IDLE, REQ, INIT, DATA, END, FIN} state_t;

    state_t      state_q, state_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [8:0]  mem_base_q, mem_base_d;
    logic [9:0]  rem_q, rem_d;
    logic [7:0]  burst_q, burst_d;
    logic [8:0]  len_q, len_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] hold_q, hold_d;
    logic        use_hold_q, use_hold_d;
    logic        err_q, err_d;
    logic [8:0]  mem_addr_q, mem_addr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        bus_req_q, bus_req_d;
    logic        begin_q, begin_d;
    logic        valid_q, valid_d;
    logic        end_q, end_d;
    logic [31:0] addr_out_q, addr_out_d;
    logic [7:0]  bcount_q, bcount_d;
    logic [9:0]  burst_len, lim;
    logic [8:0]  len_w;

    assign burst_len = {2'b00, burst_q} + 10'd1;
    assign lim       = (burst_len < 10'(maxBurst)) ? burst_len : 10'(maxBurst);
    assign len_w     = (rem_q < lim) ? rem_q[8:0] : lim[8:0];

    always_comb begin
        state_d    = state_q;
        bus_addr_d = bus_addr_q;
        mem_base_d = mem_base_q;
        rem_d      = rem_q;
        burst_d    = burst_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        use_hold_d = use_hold_q;
        err_d      = err_q;
        mem_addr_d = mem_addr_q;
        addr_out_d = '0;
        bcount_d   = '0;
        case (state_q)
            IDLE: if (start) begin
                bus_addr_d = busStartAddress & ~32'h3;
                mem_base_d = memStartAddress;
                rem_d      = blockSize;
                burst_d    = burstSize;
                err_d      = 1'b0;
                state_d    = (blockSize == 10'd0) ? FIN : REQ;
            end
            REQ: if (busGrant) begin
                len_d      = len_w;
                cnt_d      = 8'(len_w - 9'd1);
                bcount_d   = 8'(len_w - 9'd1);
                addr_out_d = bus_addr_q;
                mem_addr_d = mem_base_q;
                state_d    = INIT;
            end
            INIT: begin
                mem_addr_d = mem_addr_q + 9'd1;
                use_hold_d = 1'b0;
                err_d      = busError;
                state_d    = busError ? END : DATA;
            end
            // memAddress runs one word ahead of writeData; a stall parks the
            // presented word in hold_q while the read-ahead word sits on memData.
            DATA: if (busError) begin
                err_d   = 1'b1;
                state_d = END;
            end else if (!busBusy) begin
                mem_addr_d = mem_addr_q + 9'd1;
                use_hold_d = 1'b0;
                cnt_d      = cnt_q - 8'd1;
                state_d    = (cnt_q == 8'd0) ? END : DATA;
            end else if (!use_hold_q) begin
                hold_d     = memData;
                use_hold_d = 1'b1;
            end
            END: begin
                bus_addr_d = bus_addr_q + 32'({len_q, 2'b00});
                mem_base_d = mem_base_q + len_q;
                rem_d      = rem_q - 10'(len_q);
                state_d    = (err_q || rem_q == 10'(len_q)) ? FIN : REQ;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d    = state_d != IDLE;
        done_d    = state_d == FIN;
        bus_req_d = state_d inside {REQ, INIT, DATA};
        begin_d   = state_d == INIT;
        valid_d   = state_d == DATA;
        end_d     = state_d == END;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            bus_addr_q <= '0;
            mem_base_q <= '0;
            rem_q      <= '0;
            burst_q    <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            hold_q     <= '0;
            use_hold_q <= 1'b0;
            err_q      <= 1'b0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bus_req_q  <= 1'b0;
            begin_q    <= 1'b0;
            valid_q    <= 1'b0;
            end_q      <= 1'b0;
            addr_out_q <= '0;
            bcount_q   <= '0;
        end else begin
            state_q    <= state_d;
            bus_addr_q <= bus_addr_d;
            mem_base_q <= mem_base_d;
            rem_q      <= rem_d;
            burst_q    <= burst_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            use_hold_q <= use_hold_d;
            err_q      <= err_d;
            mem_addr_q <= mem_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bus_req_q  <= bus_req_d;
            begin_q    <= begin_d;
            valid_q    <= valid_d;
            end_q      <= end_d;
            addr_out_q <= addr_out_d;
            bcount_q   <= bcount_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign errorFlag        = err_q;
    assign memAddress       = mem_addr_q;
    assign busRequest       = bus_req_q;
    assign beginTransaction = begin_q;
    assign addressData      = addr_out_q;
    assign burstCount       = bcount_q;
    assign dataValid        = valid_q;
    assign endTransaction   = end_q;
    assign writeData        = valid_q ? (use_hold_q ? hold_q : memData) : '0;
endmodule

// File: doc/dma_mem_to_bus.md
Name: dma_mem_to_bus

Overview:
- Bus-master reader side of the custom-instruction scratch-pad memory. The CI writes words into the 512x32 dual-port RAM; this block reads them from the other RAM port and burst-writes them onto the system bus.
- It sits beside the CI memory block and shares its clock.
- A transfer is configured and started by a single-cycle start pulse. The block reports completion with a one-cycle done pulse.

Parameters:
- maxBurst, 256, largest burst length in words; burstSize+1 is clipped to this value.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; accepted only in IDLE
- busStartAddress  input  32  bus byte address; bits[1:0] ignored (word aligned)
- memStartAddress  input  9  first RAM word address
- blockSize  input  10  number of words to move (0..1023)
- burstSize  input  8  burst length minus 1
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle completion pulse
- errorFlag  output  1  valid with done; 1 = aborted by busError
- memAddress  output  9  RAM port-B read address
- memData  input  32  RAM port-B read data; registered, 1-cycle latency
- busRequest  output  1  arbitration request
- busGrant  input  1  arbitration grant
- beginTransaction  output  1  one-cycle burst start
- addressData  output  32  burst start address; nonzero only while beginTransaction is high
- burstCount  output  8  words in burst minus 1; valid with beginTransaction
- writeData  output  32  write word
- dataValid  output  1  writeData is valid
- busBusy  input  1  slave stall; when high, writeData and dataValid are held
- endTransaction  output  1  one-cycle burst end
- busError  input  1  slave error

Behaviour:
- Reset: every output is 0 on the clock after reset is sampled high. This applies at any time, including mid-burst; the bus is released immediately and no done pulse is issued.
- FSM states: IDLE, REQ, INIT, DATA, END, FIN.
- IDLE:
  - start=1 latches all configuration inputs.
  - blockSize=0: go to FIN directly; no bus activity.
  - Otherwise go to REQ.
  - start is ignored in every state other than IDLE.
- REQ:
  - busRequest=1 and stays high through DATA.
  - Move to INIT on the cycle busGrant is sampled 1.
  - busRequest is never deasserted while waiting for grant.
- INIT: one cycle with beginTransaction=1.
  - addressData = current bus address.
  - burstCount = len-1, where len = min(burstSize+1, maxBurst, remaining).
  - The RAM read of the first word is issued in this cycle.
- DATA:
  - A word is transferred on each rising edge where dataValid=1 and busBusy=0.
  - Throughput is 1 word/cycle while busBusy=0. The first dataValid is asserted the cycle after INIT.
  - During a stall, writeData is held unchanged. A read-ahead holding register guarantees no word is lost or duplicated across a stall.
  - memAddress increments modulo 512, so 511 wraps to 0.
- END:
  - Entered after the last word of the burst is accepted.
  - One cycle with endTransaction=1; busRequest=0 and dataValid=0.
  - Bus address advances by 4*len (32-bit wrap); remaining decreases by len.
  - Go to REQ if remaining>0 (re-arbitrate per burst), else FIN.
- FIN: one cycle with done=1; busy=0 on the following cycle; return to IDLE.
- busError: if sampled 1 in INIT or DATA, the next state is END. END then goes to FIN with errorFlag=1; remaining words are discarded. errorFlag is cleared by the next accepted start.
- busy is low in IDLE, including the cycle in which start is sampled.
- remaining is a 10-bit count; bus address is 32 bits; len is computed in at most 9 bits.

Test Plan:
- Reset during a DATA-phase stall (busBusy=1) -> all outputs 0 on the next cycle; a new start afterwards runs normally.
- RAM[0..3]=0x11,0x12,0x13,0x14; memStart=0, busStart=0x100, blockSize=4, burstSize=7, grant immediate, busBusy=0 -> one burst with addressData=0x100 and burstCount=3; writeData 0x11..0x14 on 4 consecutive cycles; endTransaction, then done with errorFlag=0.
- blockSize=10, burstSize=3 -> three bursts of 4,4,2 words at 0x100, 0x110, 0x120; burstCount 3,3,1; busRequest drops between bursts.
- memStart=510, blockSize=4 -> memAddress sequence 510,511,0,1; data order preserved.
- busBusy high for 3 cycles in the middle of a burst -> writeData held constant; the total accepted word count still equals blockSize with no duplicates.
- busError asserted on the 2nd word -> endTransaction on the next cycle, done with errorFlag=1, no further bus requests. Separately, blockSize=0 -> done 1 cycle after start with no busRequest. A start issued while busy is ignored.
